// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode encoding, sequencer
// states and the flag bundle produced by alu_4bit.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } seq_state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU. SUB is computed as A + ~B + 1, so carry out
// means "no borrow".
module alu_4bit
  import alu_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  alu_op_e    i_op,
  output logic [3:0] o_result,
  output alu_flags_t o_flags
);

  logic [4:0] w_sum;
  logic [4:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;

  // Opcode decode, result select and flag generation
  always_comb begin
    o_result         = 4'd0;
    o_flags.carry    = 1'b0;
    o_flags.overflow = 1'b0;
    case (i_op)
      ADD: begin
        o_result         = w_sum[3:0];
        o_flags.carry    = w_sum[4];
        o_flags.overflow = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
      end
      SUB: begin
        o_result         = w_diff[3:0];
        o_flags.carry    = w_diff[4];
        o_flags.overflow = (i_a[3] != i_b[3]) && (w_diff[3] != i_a[3]);
      end
      AND:     o_result = i_a & i_b;
      OR:      o_result = i_a | i_b;
      XOR:     o_result = i_a ^ i_b;
      NOT:     o_result = ~i_a;
      SHL:     o_result = {i_a[2:0], 1'b0};
      SHR:     o_result = {1'b0, i_a[3:1]};
      default: o_result = 4'd0;
    endcase
    o_flags.zero = (o_result == 4'd0);
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for alu_4bit: accepts a command, reads operands from a
// small register file, executes in one cycle, writes back and responds.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter  int NUM_REGS = 4,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_dst,
  input  logic [RW-1:0] cmd_src_a,
  input  logic [RW-1:0] cmd_src_b,
  input  logic          cmd_imm_en,
  input  logic [3:0]    cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [3:0]    rsp_result,
  output logic          rsp_carry,
  output logic          rsp_overflow,
  output logic          rsp_zero,
  output logic [7:0]    rsp_count,
  input  logic [RW-1:0] dbg_rd_sel,
  output logic [3:0]    dbg_rd_data
);

  seq_state_e    r_state;
  seq_state_e    w_next_state;
  logic [3:0]    r_regs [NUM_REGS];
  logic          r_load;
  alu_op_e       r_op;
  logic [RW-1:0] r_dst;
  logic [3:0]    r_a;
  logic [3:0]    r_b;
  logic [3:0]    r_rsp_result;
  alu_flags_t    r_rsp_flags;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_count;
  logic          w_cmd_fire;
  logic          w_rsp_fire;
  logic [3:0]    w_alu_result;
  alu_flags_t    w_alu_flags;
  logic [3:0]    w_result;
  alu_flags_t    w_flags;

  assign w_cmd_fire = cmd_valid && (r_state == IDLE);
  assign w_rsp_fire = rsp_ready && r_rsp_valid;

  alu_4bit u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // Loads carry the immediate in r_b and bypass the ALU
  always_comb begin
    w_result = w_alu_result;
    w_flags  = w_alu_flags;
    if (r_load) begin
      w_result         = r_b;
      w_flags.carry    = 1'b0;
      w_flags.overflow = 1'b0;
      w_flags.zero     = (r_b == 4'd0);
    end else begin
      w_result = w_alu_result;
      w_flags  = w_alu_flags;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire) w_next_state = EXEC;
        else            w_next_state = IDLE;
      end
      EXEC: w_next_state = RESP;
      RESP: begin
        if (w_rsp_fire) w_next_state = IDLE;
        else            w_next_state = RESP;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Command and operand latch at accept time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load <= 1'b0;
      r_op   <= ADD;
      r_dst  <= '0;
      r_a    <= 4'd0;
      r_b    <= 4'd0;
    end else if (w_cmd_fire) begin
      r_load <= cmd_load;
      r_op   <= alu_op_e'(cmd_op);
      r_dst  <= cmd_dst;
      r_a    <= r_regs[cmd_src_a];
      r_b    <= (cmd_load || cmd_imm_en) ? cmd_imm : r_regs[cmd_src_b];
    end
  end

  // Register file, written back in EXEC only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 4'd0;
    end else if (r_state == EXEC) begin
      r_regs[r_dst] <= w_result;
    end
  end

  // Response registers and completed-response counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= 4'd0;
      r_rsp_flags  <= 3'b000;
      r_rsp_valid  <= 1'b0;
      r_rsp_count  <= 8'd0;
    end else if (r_state == EXEC) begin
      r_rsp_result <= w_result;
      r_rsp_flags  <= w_flags;
      r_rsp_valid  <= 1'b1;
    end else if (w_rsp_fire) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_count  <= r_rsp_count + 8'd1;
    end
  end

  assign cmd_ready    = (r_state == IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_carry    = r_rsp_flags.carry;
  assign rsp_overflow = r_rsp_flags.overflow;
  assign rsp_zero     = r_rsp_flags.zero;
  assign rsp_count    = r_rsp_count;
  assign dbg_rd_data  = r_regs[dbg_rd_sel];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: expectations are computed from an
// independent integer model when a command is driven and checked on response.
module tb_alu_cmd_sequencer;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load, cmd_imm_en;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst, cmd_src_a, cmd_src_b, dbg_rd_sel;
  logic [3:0] cmd_imm, rsp_result, dbg_rd_data;
  logic       rsp_valid, rsp_ready, rsp_carry, rsp_overflow, rsp_zero;
  logic [7:0] rsp_count;

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic [1:0] dst;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       last_exp;
  logic [3:0] m_regs [4];
  logic [7:0] m_count;
  int         n_vec = 0;
  int         n_err = 0;

  alu_cmd_sequencer #(.NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_count(rsp_count), .dbg_rd_sel(dbg_rd_sel), .dbg_rd_data(dbg_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic ld, input logic [2:0] op,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] dst);
    exp_t e;
    int sa, sb, r;
    sa = (a > 4'd7) ? int'(a) - 16 : int'(a);
    sb = (b > 4'd7) ? int'(b) - 16 : int'(b);
    e.dst = dst; e.c = 1'b0; e.v = 1'b0; e.res = 4'd0;
    if (ld) e.res = b;
    else begin
      case (op)
        OP_ADD: begin
          r = int'(a) + int'(b); e.res = r[3:0]; e.c = (r > 15);
          e.v = ((sa + sb) > 7) || ((sa + sb) < -8);
        end
        OP_SUB: begin
          r = int'(a) - int'(b); e.res = r[3:0]; e.c = (a >= b);
          e.v = ((sa - sb) > 7) || ((sa - sb) < -8);
        end
        OP_AND: e.res = a & b;
        OP_OR:  e.res = a | b;
        OP_XOR: e.res = a ^ b;
        OP_NOT: e.res = 4'd15 - a;
        OP_SHL: begin r = int'(a) * 2; e.res = r[3:0]; end
        OP_SHR: e.res = a / 4'd2;
        default: e.res = 4'd0;
      endcase
    end
    e.z = (e.res == 4'd0);
    return e;
  endfunction

  // Called at a negedge: present a command and queue its expected response.
  task automatic drive_cmd(input logic ld, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic imm_en, input logic [3:0] imm);
    cmd_load = ld; cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb;
    cmd_imm_en = imm_en; cmd_imm = imm; cmd_valid = 1'b1;
    sb_q.push_back(model(ld, op, m_regs[sa], (ld || imm_en) ? imm : m_regs[sb], dst));
  endtask

  task automatic accept();
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Entered at the negedge right after the accept edge.
  task automatic wait_rsp();
    int lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      last_exp = sb_q.pop_front();
      chk("result", rsp_result, last_exp.res);
      chk("carry", rsp_carry, last_exp.c);
      chk("overflow", rsp_overflow, last_exp.v);
      chk("zero", rsp_zero, last_exp.z);
      m_regs[last_exp.dst] = last_exp.res;
      dbg_rd_sel = last_exp.dst;
      #1;
      chk("dbg_rd", dbg_rd_data, last_exp.res);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    m_count++;
    chk("rsp_count", rsp_count, m_count);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("rsp_valid_clr", rsp_valid, 0);
  endtask

  task automatic do_op(input logic ld, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic imm_en, input logic [3:0] imm);
    drive_cmd(ld, op, dst, sa, sb, imm_en, imm);
    accept();
    wait_rsp();
    finish_rsp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0;
    cmd_dst = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm_en = 1'b0;
    cmd_imm = 4'd0; rsp_ready = 1'b0; dbg_rd_sel = 2'd0;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_count = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_count", rsp_count, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_flags", {rsp_carry, rsp_overflow, rsp_zero}, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_rd_sel = 2'(i);
      #1;
      chk("rst_dbg", dbg_rd_data, 0);
    end
    @(negedge clk);

    do_op(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 4'd3);
    do_op(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 4'd5);
    do_op(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0);
    chk("add_ov_result", last_exp.res, 8);
    do_op(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 4'hF);
    do_op(1'b0, OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 4'd1);
    do_op(1'b0, OP_SUB, 2'd3, 2'd1, 2'd0, 1'b1, 4'd2);

    for (int i = 0; i < 32; i++) begin
      do_op(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Backpressure with a second command waiting on the input
    drive_cmd(1'b0, OP_ADD, 2'd2, 2'd1, 2'd3, 1'b0, 4'd0);
    accept();
    wait_rsp();
    drive_cmd(1'b1, OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 4'h9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, last_exp.res);
      chk("bp_flags", {rsp_carry, rsp_overflow, rsp_zero}, {last_exp.c, last_exp.v, last_exp.z});
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_count", rsp_count, m_count);
    end
    finish_rsp();
    accept();
    wait_rsp();
    finish_rsp();

    // Reset while the ADD sits in EXEC
    do_op(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 4'd3);
    do_op(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 4'd5);
    drive_cmd(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_count", rsp_count, 0);
    sb_q.delete();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_count = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_valid, 0);
    dbg_rd_sel = 2'd2;
    #1;
    chk("mid_rst_r2", dbg_rd_data, 0);
    @(negedge clk);

    // 257 loads: the counter wraps to 0 on the 256th and reads 1 after
    for (int i = 0; i < 257; i++) begin
      do_op(1'b1, OP_ADD, 2'(i % 4), 2'd0, 2'd0, 1'b0, 4'($urandom_range(0, 15)));
      if (i == 255) chk("wrap_zero", rsp_count, 0);
    end
    chk("wrap_one", rsp_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
